// File: rtl/keyboard_pkg.sv
// -----------------------------------------------------------------------------
// keyboard_pkg
// Shared PS/2 keyboard definitions: prefix bytes, common scan codes, the
// prefix-parser state encoding and the 9-bit {extended, scan code} key type.
// -----------------------------------------------------------------------------
package keyboard_pkg;

    // Prefix bytes of the PS/2 set-2 scan-code stream
    localparam logic [7:0] KC_EXT   = 8'hE0;
    localparam logic [7:0] KC_BREAK = 8'hF0;

    // Plain letter keys used for WSAD movement
    localparam logic [7:0] KC_W = 8'h1D;
    localparam logic [7:0] KC_S = 8'h1B;
    localparam logic [7:0] KC_A = 8'h1C;
    localparam logic [7:0] KC_D = 8'h23;

    // Arrow keys (these arrive behind an E0 prefix)
    localparam logic [7:0] KC_UP    = 8'h75;
    localparam logic [7:0] KC_DOWN  = 8'h72;
    localparam logic [7:0] KC_LEFT  = 8'h6B;
    localparam logic [7:0] KC_RIGHT = 8'h74;

    // Prefix parser states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } parser_state_t;

    // bit 8 = extended (E0) flag, [7:0] = scan code
    typedef logic [8:0] keycode_t;

    function automatic keycode_t make_keycode(input logic ext, input logic [7:0] scan);
        return {ext, scan};
    endfunction

endpackage

// File: rtl/ps2_code_parser.sv
// -----------------------------------------------------------------------------
// ps2_code_parser
// Turns the raw PS/2 byte stream into complete make/break key events by
// tracking the E0 (extended) and F0 (break) prefixes. A prefix that is not
// followed by another byte within PREFIX_TIMEOUT cycles is abandoned.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   rx_data      byte from the PS/2 receiver
//   rx_valid     single-cycle strobe qualifying rx_data
//   code_valid   high in the cycle the final byte of a code is accepted
//   code_break   event is a break (release) code
//   code         {extended, scan code} of the event
//
// The event outputs are decoded combinationally from the registered state and
// the incoming byte so that the consumer can register its outputs on the very
// edge that accepts the final byte, keeping end-to-end latency at one cycle.
// -----------------------------------------------------------------------------
module ps2_code_parser
    import keyboard_pkg::*;
#(
    parameter int unsigned PREFIX_TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       code_valid,
    output logic       code_break,
    output keycode_t   code
);

    localparam int unsigned TMR_W = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PREFIX_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    parser_state_t    state_r;
    parser_state_t    state_s;
    logic [TMR_W-1:0] timer_r;
    logic [TMR_W-1:0] timer_s;

    // Parser state and prefix timeout counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            timer_r <= TMR_ZERO;
        end else begin
            state_r <= state_s;
            timer_r <= timer_s;
        end
    end

    // Next-state, timeout and event decode
    always_comb begin
        state_s    = state_r;
        timer_s    = timer_r;
        code_valid = 1'b0;
        code_break = 1'b0;
        code       = make_keycode(1'b0, rx_data);
        if (rx_valid) begin
            timer_s = TMR_ZERO;
            case (state_r)
                IDLE: begin
                    if (rx_data == KC_EXT) begin
                        state_s = EXT;
                    end else if (rx_data == KC_BREAK) begin
                        state_s = BRK;
                    end else begin
                        code_valid = 1'b1;
                    end
                end
                EXT: begin
                    if (rx_data == KC_BREAK) begin
                        state_s = EXT_BRK;
                    end else if (rx_data == KC_EXT) begin
                        state_s = EXT;
                    end else begin
                        code_valid = 1'b1;
                        code       = make_keycode(1'b1, rx_data);
                        state_s    = IDLE;
                    end
                end
                BRK: begin
                    if (rx_data == KC_BREAK) begin
                        state_s = BRK;
                    end else if (rx_data == KC_EXT) begin
                        state_s = EXT_BRK;
                    end else begin
                        code_valid = 1'b1;
                        code_break = 1'b1;
                        state_s    = IDLE;
                    end
                end
                EXT_BRK: begin
                    if ((rx_data == KC_EXT) || (rx_data == KC_BREAK)) begin
                        state_s = EXT_BRK;
                    end else begin
                        code_valid = 1'b1;
                        code_break = 1'b1;
                        code       = make_keycode(1'b1, rx_data);
                        state_s    = IDLE;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else if (state_r != IDLE) begin
            // Waiting for the byte after a prefix; give up after the timeout
            if (timer_r == TMR_LAST) begin
                state_s = IDLE;
                timer_s = TMR_ZERO;
            end else begin
                timer_s = timer_r + TMR_ONE;
            end
        end else begin
            timer_s = TMR_ZERO;
        end
    end

endmodule

// File: rtl/key_action_mapper.sv
// -----------------------------------------------------------------------------
// key_action_mapper
// Maps PS/2 make/break codes onto NUM_ACTIONS configurable actions. Each
// action has a held level, press/release pulses and an optional auto-repeat
// pulse (first after HOLD_DELAY cycles, then every REPEAT_PERIOD cycles).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rx_data         scan-code byte from the PS/2 receiver
//   rx_valid        single-cycle strobe qualifying rx_data
//   action_held     per action: key currently down
//   action_press    per action: 1-cycle pulse on press
//   action_release  per action: 1-cycle pulse on release
//   action_repeat   per action: 1-cycle auto-repeat pulse while held
//   unmapped        1-cycle pulse: complete code matched no action
// -----------------------------------------------------------------------------
module key_action_mapper
    import keyboard_pkg::*;
#(
    parameter int unsigned NUM_ACTIONS    = 4,
    parameter keycode_t    KEYMAP [NUM_ACTIONS] = '{9'h01D, 9'h01B, 9'h023, 9'h01C},
    parameter bit          REPEAT_EN      = 1'b1,
    parameter int unsigned HOLD_DELAY     = 20_000_000,
    parameter int unsigned REPEAT_PERIOD  = 4_000_000,
    parameter int unsigned PREFIX_TIMEOUT = 1_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [NUM_ACTIONS-1:0] action_held,
    output logic [NUM_ACTIONS-1:0] action_press,
    output logic [NUM_ACTIONS-1:0] action_release,
    output logic [NUM_ACTIONS-1:0] action_repeat,
    output logic                   unmapped
);

    localparam int unsigned CNT_W = 25;
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic                   code_valid_s;
    logic                   code_break_s;
    keycode_t               code_s;
    logic [NUM_ACTIONS-1:0] match_s;
    logic                   unmapped_s;
    logic                   unmapped_r;

    ps2_code_parser #(
        .PREFIX_TIMEOUT (PREFIX_TIMEOUT)
    ) u_parser (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .code_valid (code_valid_s),
        .code_break (code_break_s),
        .code       (code_s)
    );

    // Compare the decoded event against every map entry; several may match
    always_comb begin
        match_s = {NUM_ACTIONS{1'b0}};
        for (int i = 0; i < NUM_ACTIONS; i++) begin
            match_s[i] = code_valid_s && (code_s == KEYMAP[i]);
        end
        unmapped_s = code_valid_s && (match_s == {NUM_ACTIONS{1'b0}});
    end

    // Unmapped-code pulse register
    always_ff @(posedge clk) begin
        if (rst) begin
            unmapped_r <= 1'b0;
        end else begin
            unmapped_r <= unmapped_s;
        end
    end

    assign unmapped = unmapped_r;

    for (genvar g = 0; g < NUM_ACTIONS; g++) begin : g_action
        logic             held_r,    held_s;
        logic             press_r,   press_s;
        logic             release_r, release_s;
        logic             repeat_r,  repeat_s;
        logic             periodic_r, periodic_s;
        logic [CNT_W-1:0] cnt_r,     cnt_s;
        logic             due_s;

        // periodic_r selects the reload interval once the first repeat fired
        assign due_s = periodic_r ? (cnt_r == PERIOD_LAST) : (cnt_r == HOLD_LAST);

        // Per-action held level, pulses and repeat counter next state
        always_comb begin
            held_s     = held_r;
            press_s    = 1'b0;
            release_s  = 1'b0;
            repeat_s   = 1'b0;
            periodic_s = periodic_r;
            cnt_s      = cnt_r;
            if (match_s[g] && !code_break_s && !held_r) begin
                held_s     = 1'b1;
                press_s    = 1'b1;
                cnt_s      = CNT_ZERO;
                periodic_s = 1'b0;
            end else if (match_s[g] && code_break_s && held_r) begin
                // A release that coincides with a due repeat suppresses it
                held_s     = 1'b0;
                release_s  = 1'b1;
                cnt_s      = CNT_ZERO;
                periodic_s = 1'b0;
            end else if (held_r) begin
                // Typematic re-makes of a held key land here and keep counting
                if (due_s) begin
                    repeat_s   = REPEAT_EN;
                    cnt_s      = CNT_ZERO;
                    periodic_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end else begin
                cnt_s      = CNT_ZERO;
                periodic_s = 1'b0;
            end
        end

        // Per-action state and output registers
        always_ff @(posedge clk) begin
            if (rst) begin
                held_r     <= 1'b0;
                press_r    <= 1'b0;
                release_r  <= 1'b0;
                repeat_r   <= 1'b0;
                periodic_r <= 1'b0;
                cnt_r      <= CNT_ZERO;
            end else begin
                held_r     <= held_s;
                press_r    <= press_s;
                release_r  <= release_s;
                repeat_r   <= repeat_s;
                periodic_r <= periodic_s;
                cnt_r      <= cnt_s;
            end
        end

        assign action_held[g]    = held_r;
        assign action_press[g]   = press_r;
        assign action_release[g] = release_r;
        assign action_repeat[g]  = repeat_r;
    end

endmodule

// File: tb/tb_key_action_mapper.sv
module tb_key_action_mapper;

    localparam int NA = 6;
    localparam int HD = 10;
    localparam int RP = 4;
    localparam int PT = 8;
    // up, extended-up, D, A, S, D again (duplicate exercises multi-match)
    localparam logic [8:0] MAP [NA] = '{9'h01D, 9'h175, 9'h023, 9'h01C, 9'h01B, 9'h023};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [NA-1:0] held, press, rel, rep;
    logic          unm;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    int            now = 0;
    bit            m_pfx, m_ext, m_brk;
    int            m_idle;
    logic [NA-1:0] m_held;
    int            m_pt [NA];
    logic [NA-1:0] e_press, e_rel, e_rep;
    logic          e_unm;

    key_action_mapper #(
        .NUM_ACTIONS    (NA),
        .KEYMAP         (MAP),
        .REPEAT_EN      (1'b1),
        .HOLD_DELAY     (HD),
        .REPEAT_PERIOD  (RP),
        .PREFIX_TIMEOUT (PT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .action_held    (held),
        .action_press   (press),
        .action_release (rel),
        .action_repeat  (rep),
        .unmapped       (unm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, now, act, exp);
        end
    endtask

    // Behavioural model: prefix flags plus per-key press timestamps
    task automatic model_step(input logic r, input logic v, input logic [7:0] d);
        bit         ev, ev_brk, any, due;
        logic [8:0] ev_code;
        int         el;
        now++;
        e_press = '0; e_rel = '0; e_rep = '0; e_unm = 1'b0;
        ev = 0; ev_brk = 0; ev_code = 9'h000; any = 0;
        if (r) begin
            m_pfx = 0; m_ext = 0; m_brk = 0; m_idle = 0; m_held = '0;
        end else begin
            if (v) begin
                m_idle = 0;
                if (d == 8'hE0) begin
                    m_pfx = 1; m_ext = 1;
                end else if (d == 8'hF0) begin
                    m_pfx = 1; m_brk = 1;
                end else begin
                    ev = 1; ev_brk = m_brk; ev_code = {m_ext, d};
                    m_pfx = 0; m_ext = 0; m_brk = 0;
                end
            end else if (m_pfx) begin
                m_idle++;
                if (m_idle == PT) begin
                    m_pfx = 0; m_ext = 0; m_brk = 0; m_idle = 0;
                end
            end
            for (int i = 0; i < NA; i++) begin
                el  = now - m_pt[i];
                due = m_held[i] && (el >= HD) && (((el - HD) % RP) == 0);
                if (ev && (MAP[i] == ev_code)) begin
                    any = 1;
                    if (!ev_brk && !m_held[i]) begin
                        m_held[i] = 1'b1; m_pt[i] = now; e_press[i] = 1'b1;
                    end else if (ev_brk && m_held[i]) begin
                        m_held[i] = 1'b0; e_rel[i] = 1'b1; due = 0;
                    end
                end
                e_rep[i] = due;
            end
            e_unm = ev && !any;
        end
    endtask

    // One clock: drive on the falling edge, compare after the rising edge
    task automatic tick(input logic r, input logic v, input logic [7:0] d);
        @(negedge clk);
        rst = r; rx_valid = v; rx_data = d;
        model_step(r, v, d);
        @(posedge clk);
        #1;
        chk("model held", 32'(held), 32'(m_held));
        chk("model press", 32'(press), 32'(e_press));
        chk("model release", 32'(rel), 32'(e_rel));
        chk("model repeat", 32'(rep), 32'(e_rep));
        chk("model unmapped", 32'(unm), 32'(e_unm));
    endtask

    typedef struct packed {
        logic          r;
        logic          v;
        logic [7:0]    d;
        logic [NA-1:0] held;
        logic [NA-1:0] press;
        logic [NA-1:0] rel;
        logic          unm;
    } vec_t;

    vec_t tbl[$];

    initial begin
        vec_t t;
        logic [7:0] b;
        int sel;

        // r, v, byte, held, press, release, unmapped (state after that edge)
        tbl.push_back('{1'b1, 1'b0, 8'h00, 6'h00, 6'h00, 6'h00, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'hF0, 6'h00, 6'h00, 6'h00, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 8'h00, 6'h00, 6'h00, 6'h00, 1'b0}); // reset mid-prefix
        tbl.push_back('{1'b0, 1'b1, 8'h1D, 6'h01, 6'h01, 6'h00, 1'b0}); // make, not break
        tbl.push_back('{1'b0, 1'b0, 8'h00, 6'h01, 6'h00, 6'h00, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'hF0, 6'h01, 6'h00, 6'h00, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'h1D, 6'h00, 6'h00, 6'h01, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 8'h00, 6'h00, 6'h00, 6'h00, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'hE0, 6'h00, 6'h00, 6'h00, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'h75, 6'h02, 6'h02, 6'h00, 1'b0}); // E0 75
        tbl.push_back('{1'b0, 1'b1, 8'h75, 6'h02, 6'h00, 6'h00, 1'b1}); // plain 75
        tbl.push_back('{1'b0, 1'b1, 8'hE0, 6'h02, 6'h00, 6'h00, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'hF0, 6'h02, 6'h00, 6'h00, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'h75, 6'h00, 6'h00, 6'h02, 1'b0}); // E0 F0 75
        tbl.push_back('{1'b0, 1'b1, 8'hF0, 6'h00, 6'h00, 6'h00, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'h1B, 6'h00, 6'h00, 6'h00, 1'b0}); // break of unheld
        tbl.push_back('{1'b0, 1'b1, 8'hF0, 6'h00, 6'h00, 6'h00, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'hE0, 6'h00, 6'h00, 6'h00, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'h75, 6'h00, 6'h00, 6'h00, 1'b0}); // F0 E0 75 unheld
        tbl.push_back('{1'b0, 1'b1, 8'h23, 6'h24, 6'h24, 6'h00, 1'b0}); // two actions match
        tbl.push_back('{1'b0, 1'b1, 8'hF0, 6'h24, 6'h00, 6'h00, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'h23, 6'h00, 6'h00, 6'h24, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'hF0, 6'h00, 6'h00, 6'h00, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 8'h55, 6'h00, 6'h00, 6'h00, 1'b1}); // unmapped break
        tbl.push_back('{1'b0, 1'b1, 8'h1C, 6'h08, 6'h08, 6'h00, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 8'h1D, 6'h00, 6'h00, 6'h00, 1'b0}); // reset wins
        tbl.push_back('{1'b0, 1'b0, 8'h00, 6'h00, 6'h00, 6'h00, 1'b0});

        foreach (tbl[k]) begin
            t = tbl[k];
            tick(t.r, t.v, t.d);
            chk("tbl held", 32'(held), 32'(t.held));
            chk("tbl press", 32'(press), 32'(t.press));
            chk("tbl release", 32'(rel), 32'(t.rel));
            chk("tbl repeat", 32'(rep), 32'(0));
            chk("tbl unmapped", 32'(unm), 32'(t.unm));
        end

        // Typematic re-make and auto-repeat: press at k=0, repeats at 10 and 14,
        // release at 18 swallows the repeat that is due in the same cycle
        for (int k = 0; k <= 22; k++) begin
            if (k == 17) tick(1'b0, 1'b1, 8'hF0);
            else if (k == 0 || k == 5 || k == 18) tick(1'b0, 1'b1, 8'h23);
            else tick(1'b0, 1'b0, 8'h00);
            chk("rpt press", 32'(press), (k == 0) ? 32'h24 : 32'h0);
            chk("rpt held", 32'(held), (k < 18) ? 32'h24 : 32'h0);
            chk("rpt release", 32'(rel), (k == 18) ? 32'h24 : 32'h0);
            chk("rpt repeat", 32'(rep), (k == 10 || k == 14) ? 32'h24 : 32'h0);
        end

        // Prefix timeout: 8 idle cycles abandon F0, 7 do not
        tick(1'b0, 1'b1, 8'h1C);
        chk("to press0", 32'(press[3]), 32'd1);
        tick(1'b0, 1'b1, 8'hF0);
        repeat (PT) tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 8'h1C);
        chk("to8 release", 32'(rel[3]), 32'd0);
        chk("to8 held", 32'(held[3]), 32'd1);
        chk("to8 press", 32'(press[3]), 32'd0);
        tick(1'b0, 1'b1, 8'hF0);
        repeat (PT - 1) tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 8'h1C);
        chk("to7 release", 32'(rel[3]), 32'd1);
        chk("to7 held", 32'(held[3]), 32'd0);
        tick(1'b0, 1'b1, 8'hF0);
        repeat (PT) tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 8'h1C);
        chk("to8b press", 32'(press[3]), 32'd1);
        chk("to8b release", 32'(rel[3]), 32'd0);
        tick(1'b0, 1'b1, 8'hF0);
        tick(1'b0, 1'b1, 8'h1C);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 199);
            if (sel < 1) begin
                tick(1'b1, 1'b0, 8'h00);
            end else if (sel < 12) begin
                repeat ($urandom_range(5, 12)) tick(1'b0, 1'b0, 8'h00);
            end else if (sel < 100) begin
                tick(1'b0, 1'b0, 8'h00);
            end else begin
                case ($urandom_range(0, 8))
                    0: b = 8'hE0;
                    1: b = 8'hF0;
                    2: b = 8'hF0;
                    3: b = 8'h1D;
                    4: b = 8'h75;
                    5: b = 8'h23;
                    6: b = 8'h1C;
                    7: b = 8'h1B;
                    default: b = 8'($urandom_range(0, 255));
                endcase
                tick(1'b0, 1'b1, b);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
